// File: rtl/if_id_reg_pkg.sv
// Shared widths, the idle NOP word and the IF/ID buffer state encoding.
package if_id_reg_pkg;
   localparam int          XLEN     = 64;
   localparam int          ILEN     = 32;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IFID_EMPTY = 2'd0,
      IFID_ONE   = 2'd1,
      IFID_FULL  = 2'd2
   } ifid_state_e;
endpackage

// File: rtl/if_id_reg_if.sv
// Valid/ready instruction bus carrying pc, predicted next pc and the instruction word.
interface if_id_reg_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
);
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [ILEN-1:0] instr;

   modport master (output valid, pc, pc_next, instr, input ready);
   modport slave  (input valid, pc, pc_next, instr, output ready);
endinterface

// File: rtl/if_id_reg_slot.sv
// One payload register (pc, pc_next, instr); clear forces the instruction to NOP.
module if_id_slot
   import if_id_reg_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter logic [ILEN-1:0] NOP_INST = ILEN'(INST_NOP)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clr,
   input  logic            i_ld,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_pc_next,
   input  logic [ILEN-1:0] i_instr,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_next,
   output logic [ILEN-1:0] o_instr
);
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_next;
   logic [ILEN-1:0] r_instr;

   // Clear only replaces the instruction; the pc fields keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= '0;
         r_pc_next <= '0;
         r_instr   <= NOP_INST;
      end else if (i_clr) begin
         r_instr   <= NOP_INST;
      end else if (i_ld) begin
         r_pc      <= i_pc;
         r_pc_next <= i_pc_next;
         r_instr   <= i_instr;
      end
   end

   assign o_pc      = r_pc;
   assign o_pc_next = r_pc_next;
   assign o_instr   = r_instr;
endmodule

// File: rtl/if_id_reg.sv
// Fetch/decode boundary: 2-entry skid buffer so if_ready never sees id_ready combinationally.
module if_id_reg
   import if_id_reg_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter logic [ILEN-1:0] NOP_INST = ILEN'(INST_NOP)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   if_id_reg_if.slave  if_s,
   if_id_reg_if.master id_m,
   output logic [1:0]  occupancy_o
);
   ifid_state_e     r_state;
   ifid_state_e     w_state_nxt;
   logic            w_push;
   logic            w_pop;
   logic            w_head_ld;
   logic            w_head_from_skid;
   logic            w_skid_ld;
   logic [XLEN-1:0] w_skid_pc;
   logic [XLEN-1:0] w_skid_pc_next;
   logic [ILEN-1:0] w_skid_instr;
   logic [XLEN-1:0] w_head_pc_in;
   logic [XLEN-1:0] w_head_pc_next_in;
   logic [ILEN-1:0] w_head_instr_in;

   assign if_s.ready  = (r_state != IFID_FULL);
   assign id_m.valid  = (r_state != IFID_EMPTY);
   assign occupancy_o = r_state;

   assign w_push = if_s.valid & if_s.ready;
   assign w_pop  = id_m.valid & id_m.ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IFID_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_head_ld        = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
      case (r_state)
         IFID_EMPTY: if (w_push) begin
            w_head_ld   = 1'b1;
            w_state_nxt = IFID_ONE;
         end
         IFID_ONE: begin
            if (w_push && !w_pop) begin
               w_skid_ld   = 1'b1;
               w_state_nxt = IFID_FULL;
            end else if (w_pop && !w_push) begin
               w_state_nxt = IFID_EMPTY;
            end else if (w_push && w_pop) begin
               w_head_ld   = 1'b1;
            end
         end
         IFID_FULL: if (w_pop) begin
            w_head_ld        = 1'b1;
            w_head_from_skid = 1'b1;
            w_state_nxt      = IFID_ONE;
         end
         default: w_state_nxt = IFID_EMPTY;
      endcase
      // Flush wins over any handshake; a concurrent push is dropped.
      if (flush_i) begin
         w_state_nxt = IFID_EMPTY;
         w_head_ld   = 1'b0;
         w_skid_ld   = 1'b0;
      end
   end

   assign w_head_pc_in      = w_head_from_skid ? w_skid_pc      : if_s.pc;
   assign w_head_pc_next_in = w_head_from_skid ? w_skid_pc_next : if_s.pc_next;
   assign w_head_instr_in   = w_head_from_skid ? w_skid_instr   : if_s.instr;

   if_id_slot #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INST(NOP_INST)) u_head (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (flush_i),
      .i_ld      (w_head_ld),
      .i_pc      (w_head_pc_in),
      .i_pc_next (w_head_pc_next_in),
      .i_instr   (w_head_instr_in),
      .o_pc      (id_m.pc),
      .o_pc_next (id_m.pc_next),
      .o_instr   (id_m.instr)
   );

   if_id_slot #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INST(NOP_INST)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (flush_i),
      .i_ld      (w_skid_ld),
      .i_pc      (if_s.pc),
      .i_pc_next (if_s.pc_next),
      .i_instr   (if_s.instr),
      .o_pc      (w_skid_pc),
      .o_pc_next (w_skid_pc_next),
      .o_instr   (w_skid_instr)
   );
endmodule

// File: tb/tb_if_id_reg.sv
// Randomized + directed bench for if_id_reg against a queue-based FIFO model.
module tb_if_id_reg;
   import if_id_reg_pkg::*;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] pcn;
      logic [31:0] ins;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [1:0] occ;

   if_id_reg_if #(.XLEN(64), .ILEN(32)) f_bus ();
   if_id_reg_if #(.XLEN(64), .ILEN(32)) d_bus ();

   if_id_reg dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .if_s        (f_bus),
      .id_m        (d_bus),
      .occupancy_o (occ)
   );

   always #5 clk = ~clk;

   ent_t q[$];
   ent_t shown;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 0;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // Model comparison once per cycle, mid-period.
   always @(negedge clk) if (chk_en) begin
      chk("if_ready", 64'(f_bus.ready), 64'(q.size() < 2));
      chk("id_valid", 64'(d_bus.valid), 64'(q.size() > 0));
      chk("occupancy", 64'(occ), 64'(q.size()));
      chk("id_pc", d_bus.pc, shown.pc);
      chk("id_pc_next", d_bus.pc_next, shown.pcn);
      chk("id_instr", 64'(d_bus.instr), 64'(shown.ins));
   end

   task automatic step(input logic r, input logic f, input logic v, input logic rd,
                       input logic [63:0] pc, input logic [63:0] pcn, input logic [31:0] ins);
      bit   push, pop;
      ent_t e;
      rst = r; flush = f;
      f_bus.valid = v; f_bus.pc = pc; f_bus.pc_next = pcn; f_bus.instr = ins;
      d_bus.ready = rd;
      push = v && (q.size() < 2);
      pop  = rd && (q.size() > 0);
      e.pc = pc; e.pcn = pcn; e.ins = ins;
      @(posedge clk);
      if (r) begin
         q.delete();
         shown.pc = '0; shown.pcn = '0; shown.ins = INST_NOP;
      end else if (f) begin
         q.delete();
         shown.ins = INST_NOP;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
         if (q.size() > 0) shown = q[0];
      end
      #1;
   endtask

   localparam logic [63:0] PA = 64'h8000_0000;
   localparam logic [63:0] PB = 64'h8000_0004;
   localparam logic [63:0] PC = 64'h8000_0008;
   localparam logic [63:0] PD = 64'h8000_000c;

   initial begin
      f_bus.valid = 0; f_bus.pc = '0; f_bus.pc_next = '0; f_bus.instr = '0;
      d_bus.ready = 0;
      shown.pc = '0; shown.pcn = '0; shown.ins = INST_NOP;

      step(1, 0, 0, 0, 0, 0, 0);
      chk_en = 1;
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("rst_valid", 64'(d_bus.valid), 64'd0);
      chk("rst_ready", 64'(f_bus.ready), 64'd1);
      chk("rst_instr", 64'(d_bus.instr), 64'h13);
      chk("rst_occ", 64'(occ), 64'd0);

      // Streaming with decode always ready.
      step(0, 0, 1, 1, PA, PB, 32'h0000_0101);
      chk("str_pc0", d_bus.pc, PA);
      step(0, 0, 1, 1, PB, PC, 32'h0000_0202);
      chk("str_pc1", d_bus.pc, PB);
      step(0, 0, 1, 1, PC, PD, 32'h0000_0303);
      chk("str_pc2", d_bus.pc, PC);
      chk("str_occ", 64'(occ), 64'd1);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("str_drain", 64'(occ), 64'd0);

      // Back-pressure fills the skid; third offer must stall.
      step(0, 0, 1, 0, PA, PB, 32'h0000_0aaa);
      step(0, 0, 1, 0, PB, PC, 32'h0000_0bbb);
      chk("bp_occ", 64'(occ), 64'd2);
      chk("bp_ready", 64'(f_bus.ready), 64'd0);
      chk("bp_pc", d_bus.pc, PA);
      step(0, 0, 1, 0, PC, PD, 32'h0000_0ccc);
      chk("bp_hold_pc", d_bus.pc, PA);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("bp_pop_pc", d_bus.pc, PB);
      chk("bp_pop_ready", 64'(f_bus.ready), 64'd1);

      // Push and pop together in ONE.
      step(0, 0, 1, 1, PC, PD, 32'h0000_0ccc);
      chk("pp_pc", d_bus.pc, PC);
      chk("pp_occ", 64'(occ), 64'd1);

      // Flush in FULL with a concurrent offer of D.
      step(0, 0, 1, 0, PD, PA, 32'h0000_0ddd);
      chk("fl_pre_occ", 64'(occ), 64'd2);
      step(0, 1, 1, 0, PD, PA, 32'h0000_0eee);
      chk("fl_valid", 64'(d_bus.valid), 64'd0);
      chk("fl_instr", 64'(d_bus.instr), 64'h13);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("fl_no_d", 64'(d_bus.valid), 64'd0);

      // Reset plus flush while FULL and popping.
      step(0, 0, 1, 0, PA, PB, 32'h0000_0111);
      step(0, 0, 1, 0, PB, PC, 32'h0000_0222);
      step(1, 1, 1, 1, PC, PD, 32'h0000_0333);
      chk("mr_pc", d_bus.pc, 64'd0);
      chk("mr_instr", 64'(d_bus.instr), 64'h13);
      chk("mr_occ", 64'(occ), 64'd0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("mr_no_stale", 64'(d_bus.valid), 64'd0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 200) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
              ($urandom % 3) != 0, {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
      end

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline boundary between the fetch stage and the decode stage.
- Captures each fetched instruction together with its PC and predicted next-PC, and presents them to decode through a valid/ready handshake.
- Contains a 2-entry skid buffer. This lets decode back-pressure fetch without any combinational path from id_ready_i to if_ready_o.
- Supports a flush from the redirect logic, which discards all buffered and in-flight fetches.

Parameters:
- XLEN, 64, width of PC values (matches `XLEN).
- ILEN, 32, instruction width (matches `inst_len).
- NOP_INST, 32'h0000_0013, instruction presented when the register holds nothing valid (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush_i  input  1  discard all contents; asserted by the branch/jump redirect logic.
- if_valid_i  input  1  fetch presents a valid instruction this cycle.
- if_ready_o  output  1  register can accept from fetch this cycle.
- if_pc_i  input  XLEN  PC of the fetched instruction.
- if_pc_next_i  input  XLEN  next PC chosen by fetch.
- if_instr_i  input  ILEN  fetched instruction word.
- id_valid_o  output  1  head entry valid toward decode.
- id_ready_i  input  1  decode accepts the head entry this cycle.
- id_pc_o  output  XLEN  PC of the head entry.
- id_pc_next_o  output  XLEN  next PC of the head entry.
- id_instr_o  output  ILEN  instruction word of the head entry.
- occupancy_o  output  2  number of valid entries (0..2).

Behaviour:
- Transfer rules:
  - push = if_valid_i & if_ready_o.
  - pop = id_valid_o & id_ready_i.
- State machine states: EMPTY (0 entries), ONE (head valid), FULL (head and skid valid).
- if_ready_o = (state != FULL). It is decoded from registered state only; it never depends on id_ready_i.
- id_valid_o = (state != EMPTY). id_pc_o, id_pc_next_o and id_instr_o come straight from the head registers.
- Transitions when there is no flush:
  - EMPTY: on push, load the head and go to ONE.
  - ONE:
    - push and no pop: load the skid, go to FULL.
    - pop and no push: go to EMPTY.
    - push and pop together: load the head with the new entry, stay in ONE.
  - FULL:
    - on pop, copy the skid into the head and go to ONE.
    - push cannot occur because if_ready_o is 0.
- Ordering is strictly FIFO. No entry is duplicated or dropped unless a flush occurs.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle).
- Throughput: one entry per cycle when decode is always ready.
- Flush (flush_i=1):
  - Next state is EMPTY, regardless of push or pop in the same cycle.
  - An entry handshaken on the fetch side in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed for decode. Flush gating of decode side effects is decode's job.
  - After a flush, id_instr_o = NOP_INST.
- Reset (rst=1): has priority over flush and over every handshake, and applies even mid-transfer. After reset:
  - state EMPTY, id_valid_o=0, if_ready_o=1, occupancy_o=0.
  - id_pc_o=0, id_pc_next_o=0, id_instr_o=NOP_INST.
  - skid registers = 0.
- Head payload when the head is not valid:
  - Holds the last value, except after reset or flush, where instr is NOP_INST.
- occupancy_o: 0/1/2 for EMPTY/ONE/FULL. It is registered, with no glitch path.
- Widths: all payload fields are stored at full width. No arithmetic is performed in this block.

Decomposition:
- defines.v gains:
  - `INST_NOP (32'h0000_0013).
  - state encodings `IFID_EMPTY=2'd0, `IFID_ONE=2'd1, `IFID_FULL=2'd2.
  - `XLEN and `inst_len are reused.
- One sub-module, if_id_slot: a payload register (pc, pc_next, instr) with load enable, synchronous reset to {0,0,`INST_NOP}, and a clear-to-NOP input. It is instantiated twice, as head and skid.

Test Plan:
- Reset then idle. Hold rst=1 for 2 cycles, then release → id_valid_o=0, if_ready_o=1, id_instr_o=32'h00000013, occupancy_o=0.
- Streaming. Hold id_ready_i=1 and push pc=0x80000000,0x80000004,0x80000008 on consecutive cycles → each appears on id_pc_o one cycle later, with back-to-back id_valid_o and occupancy_o stuck at 1.
- Back-pressure and skid:
  - id_ready_i=0, push A(pc 0x80000000) and B(pc 0x80000004) → occupancy_o=2, if_ready_o=0, id_pc_o=0x80000000, and a third valid offer is not accepted.
  - Then raise id_ready_i → A is popped, B is presented next cycle, and if_ready_o=1.
- Simultaneous push and pop in ONE. Head is A; push C with id_ready_i=1 → next cycle id_pc_o=C's pc and occupancy_o stays 1.
- Flush in FULL. With A and B buffered, assert flush_i while fetch also offers D → next cycle id_valid_o=0, occupancy_o=0, id_instr_o=32'h00000013. D never appears.
- Reset mid-operation. Assert rst and flush_i together while in FULL with decode popping → the reset values above appear after one edge, with no stale entry surfacing afterwards.
